// File: rtl/sha3512_absorb_ctrl_if.sv
// Message-side valid/ready channel for the SHA3-512 absorb controller.
// Carries one 64-bit little-endian lane per transfer plus last/byte-count tags.
interface sha3512_absorb_ctrl_if;
  logic [63:0] inMsgWord;
  logic        inMsgValid;
  logic        inMsgLast;
  logic [3:0]  inMsgBytes;
  logic        outMsgReady;

  modport master (
    output inMsgWord,
    output inMsgValid,
    output inMsgLast,
    output inMsgBytes,
    input  outMsgReady
  );

  modport slave (
    input  inMsgWord,
    input  inMsgValid,
    input  inMsgLast,
    input  inMsgBytes,
    output outMsgReady
  );
endinterface

// File: rtl/sha3512_absorb_ctrl.sv
// SHA3-512 absorb controller: packs lanes into 72-byte rate blocks and pads.
// Optional block counter output enabled by SHA3_ABSORB_BLKCNT_EN.
module sha3512_absorb_ctrl (
  input  logic                 inClk,
  input  logic                 inRst,
  sha3512_absorb_ctrl_if.slave msg,
  output logic [575:0]         outBlock,
  output logic                 outCoreInit,
  output logic                 outCoreWr,
  input  logic                 inCoreDone,
  output logic                 outDone,
  output logic                 outBusy
`ifdef SHA3_ABSORB_BLKCNT_EN
  ,
  output logic [15:0]          outBlockCount
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_FILL,
    S_PADBLK,
    S_ISSUE,
    S_WAIT,
    S_FIN
  } state_e;

  state_e         state_q, state_d;
  logic [3:0]     idx_q, idx_d;
  logic [575:0]   blk_q, blk_d;
  logic           fin_q, fin_d;
  logic           pad_q, pad_d;
  logic [3:0]     nbytes;
  logic [63:0]    wdat;
  logic [6:0]     padpos;
`ifdef SHA3_ABSORB_BLKCNT_EN
  logic [15:0]    cnt_q, cnt_d;
`endif

  always_ff @(posedge inClk) begin
    if (inRst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      blk_q   <= '0;
      fin_q   <= 1'b0;
      pad_q   <= 1'b0;
`ifdef SHA3_ABSORB_BLKCNT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      blk_q   <= blk_d;
      fin_q   <= fin_d;
      pad_q   <= pad_d;
`ifdef SHA3_ABSORB_BLKCNT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    blk_d   = blk_q;
    fin_d   = fin_q;
    pad_d   = pad_q;
`ifdef SHA3_ABSORB_BLKCNT_EN
    cnt_d   = cnt_q;
`endif
    nbytes = (msg.inMsgBytes > 4'd8) ? 4'd8 : msg.inMsgBytes;
    // Bytes past the count of a final word are forced to zero before padding
    for (int b = 0; b < 8; b++) begin
      if (!msg.inMsgLast || b < int'(nbytes))
        wdat[8*b +: 8] = msg.inMsgWord[8*b +: 8];
      else
        wdat[8*b +: 8] = 8'h00;
    end
    padpos = {idx_q, 3'b000} + {3'b000, nbytes};

    unique case (state_q)
      S_IDLE: begin
        if (msg.inMsgValid)
          state_d = S_INIT;
      end
      S_INIT: begin
        blk_d   = '0;
        idx_d   = '0;
        fin_d   = 1'b0;
        pad_d   = 1'b0;
`ifdef SHA3_ABSORB_BLKCNT_EN
        cnt_d   = '0;
`endif
        state_d = S_FILL;
      end
      S_FILL: begin
        if (msg.inMsgValid) begin
          blk_d[{idx_q, 6'b000000} +: 64] = wdat;
          idx_d = idx_q + 4'd1;
          if (msg.inMsgLast) begin
            if (nbytes == 4'd8 && idx_q == 4'd8) begin
              // Full final block: padding spills into its own block
              pad_d = 1'b1;
            end else begin
              blk_d[{padpos, 3'b000} +: 8] =
                blk_d[{padpos, 3'b000} +: 8] | 8'h06;
              blk_d[575:568] = blk_d[575:568] | 8'h80;
              fin_d = 1'b1;
            end
            state_d = S_ISSUE;
          end else if (idx_q == 4'd8) begin
            state_d = S_ISSUE;
          end
        end
      end
      S_PADBLK: begin
        blk_d          = '0;
        blk_d[7:0]     = 8'h06;
        blk_d[575:568] = 8'h80;
        fin_d          = 1'b1;
        pad_d          = 1'b0;
        state_d        = S_ISSUE;
      end
      S_ISSUE: begin
`ifdef SHA3_ABSORB_BLKCNT_EN
        if (cnt_q != 16'hFFFF)
          cnt_d = cnt_q + 16'd1;
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (inCoreDone) begin
          if (fin_q) begin
            state_d = S_FIN;
          end else if (pad_q) begin
            state_d = S_PADBLK;
          end else begin
            blk_d   = '0;
            idx_d   = '0;
            state_d = S_FILL;
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign outBlock        = blk_q;
  assign msg.outMsgReady = !inRst && state_q == S_FILL;
  assign outCoreInit     = !inRst && state_q == S_INIT;
  assign outCoreWr       = !inRst && state_q == S_ISSUE;
  assign outDone         = !inRst && state_q == S_FIN;
  assign outBusy         = !inRst && state_q != S_IDLE;
`ifdef SHA3_ABSORB_BLKCNT_EN
  assign outBlockCount   = cnt_q;
`endif

endmodule

// File: tb/tb_sha3512_absorb_ctrl.sv
// Randomized bench for sha3512_absorb_ctrl against a byte-level padding model.
// Core is emulated with random permutation latency.
module tb_sha3512_absorb_ctrl;

  typedef logic [7:0] bq_t[$];

  logic         clk = 1'b0;
  logic         rst;
  logic [575:0] blk;
  logic         init, wr, done_core, done, busy;
`ifdef SHA3_ABSORB_BLKCNT_EN
  logic [15:0]  bcnt;
`endif

  always #5 clk = ~clk;

  sha3512_absorb_ctrl_if mif();

  sha3512_absorb_ctrl dut (
    .inClk       (clk),
    .inRst       (rst),
    .msg         (mif),
    .outBlock    (blk),
    .outCoreInit (init),
    .outCoreWr   (wr),
    .inCoreDone  (done_core),
    .outDone     (done),
    .outBusy     (busy)
`ifdef SHA3_ABSORB_BLKCNT_EN
    ,
    .outBlockCount (bcnt)
`endif
  );

  int checks = 0;
  int fails  = 0;
  int wr_seen = 0;
  int done_seen = 0;
  int init_seen = 0;
  bit core_hold = 0;
  logic [575:0] exp_q[$];
  bit fin_q[$];

  task automatic chk(input string tag, input logic [575:0] got,
                     input logic [575:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: SHA3 pad10*1 with domain byte 0x06 over the byte string
  function automatic int model(input bq_t m);
    int L = m.size();
    int nb = L / 72 + 1;
    logic [7:0] p[];
    logic [575:0] b;
    p = new[nb * 72];
    foreach (p[i]) p[i] = 8'h00;
    foreach (m[i]) p[i] = m[i];
    p[L] = p[L] ^ 8'h06;
    p[nb*72-1] = p[nb*72-1] ^ 8'h80;
    for (int k = 0; k < nb; k++) begin
      for (int i = 0; i < 72; i++) b[8*i +: 8] = p[72*k + i];
      exp_q.push_back(b);
      fin_q.push_back(k == nb - 1);
    end
    return nb;
  endfunction

  function automatic bq_t rnd_msg(input int L);
    bq_t m;
    for (int i = 0; i < L; i++) m.push_back(8'($urandom));
    return m;
  endfunction

  always @(negedge clk) begin
    if (done) done_seen++;
    if (init) init_seen++;
  end

  // Core emulation: capture each issued block, answer after a delay
  initial begin
    logic [575:0] e;
    bit f;
    done_core = 1'b0;
    forever begin
      @(negedge clk);
      if (wr) begin
        wr_seen++;
        if (exp_q.size() == 0) begin
          chk("unexpected_wr", 576'(1), 576'(0));
          f = 0;
        end else begin
          e = exp_q.pop_front();
          f = fin_q.pop_front();
          chk("block", blk, e);
        end
        if (!core_hold) begin
          repeat (1 + $urandom_range(0, 5)) @(negedge clk);
          done_core = 1'b1;
          @(negedge clk);
          done_core = 1'b0;
          chk("done_after_core", 576'(done), 576'(f));
        end
      end
    end
  end

  task automatic send(input bq_t m);
    int L, nw, nb, t;
    logic [63:0] wd;
    bit r;
    L  = m.size();
    nw = (L == 0) ? 1 : (L + 7) / 8;
    for (int w = 0; w < nw; w++) begin
      wd = {$urandom, $urandom};
      for (int b = 0; b < 8; b++)
        if (8*w + b < L) wd[8*b +: 8] = m[8*w + b];
      nb = L - 8*w;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      mif.inMsgWord  = wd;
      mif.inMsgLast  = (w == nw - 1);
      if (w != nw - 1)
        mif.inMsgBytes = 4'($urandom);
      else if (nb >= 8)
        mif.inMsgBytes = 4'($urandom_range(8, 15));
      else
        mif.inMsgBytes = 4'(nb);
      mif.inMsgValid = 1'b1;
      r = 0;
      t = 0;
      while (!r && t <= 3000) begin
        @(negedge clk);
        r = mif.outMsgReady;
        @(posedge clk);
        #1;
        t++;
      end
      mif.inMsgValid = 1'b0;
      if (!r) begin
        chk("accept_timeout", 576'(0), 576'(1));
        return;
      end
    end
  endtask

  task automatic run_msg(input bq_t m);
    int nb, w0, d0, i0, t;
    w0 = wr_seen;
    d0 = done_seen;
    i0 = init_seen;
    nb = model(m);
    send(m);
    t = 0;
    while (done_seen == d0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    chk("done_pulses", 576'(done_seen - d0), 576'(1));
    chk("wr_count", 576'(wr_seen - w0), 576'(nb));
    chk("init_count", 576'(init_seen - i0), 576'(1));
    chk("busy_idle", 576'(busy), 576'(0));
    chk("model_drained", 576'(exp_q.size()), 576'(0));
`ifdef SHA3_ABSORB_BLKCNT_EN
    chk("blk_count", 576'(bcnt), 576'(nb));
`endif
    exp_q.delete();
    fin_q.delete();
  endtask

  initial begin
    bq_t m;
    int w0, d0, t;
    rst = 1'b1;
    mif.inMsgValid = 1'b0;
    mif.inMsgLast  = 1'b0;
    mif.inMsgBytes = 4'd0;
    mif.inMsgWord  = 64'd0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 576'(mif.outMsgReady), 576'(0));
    chk("rst_init", 576'(init), 576'(0));
    chk("rst_wr", 576'(wr), 576'(0));
    chk("rst_done", 576'(done), 576'(0));
    chk("rst_busy", 576'(busy), 576'(0));
    chk("rst_block", blk, 576'(0));
    rst = 1'b0;
    @(negedge clk);

    run_msg(rnd_msg(0));
    m = {8'h61, 8'h62, 8'h63};
    run_msg(m);
    run_msg(rnd_msg(71));
    run_msg(rnd_msg(72));
    run_msg(rnd_msg(64));
    run_msg(rnd_msg(143));
    run_msg(rnd_msg(144));
    for (int i = 0; i < 20; i++)
      run_msg(rnd_msg($urandom_range(0, 220)));

    // Reset while the core is busy on block one of a two-block message
    core_hold = 1;
    w0 = wr_seen;
    void'(model(rnd_msg(72)));
    m = rnd_msg(72);
    exp_q.delete();
    fin_q.delete();
    void'(model(m));
    fork
      send(m);
    join_none
    t = 0;
    while (wr_seen == w0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("hold_wr_seen", 576'(wr_seen - w0), 576'(1));
    @(negedge clk);
    chk("in_wait_busy", 576'(busy), 576'(1));
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", 576'(busy), 576'(0));
    chk("mid_rst_wr", 576'(wr), 576'(0));
    chk("mid_rst_ready", 576'(mif.outMsgReady), 576'(0));
    chk("mid_rst_block", blk, 576'(0));
`ifdef SHA3_ABSORB_BLKCNT_EN
    chk("mid_rst_cnt", 576'(bcnt), 576'(0));
`endif
    rst = 1'b0;
    exp_q.delete();
    fin_q.delete();
    core_hold = 0;
    w0 = wr_seen;
    d0 = done_seen;
    done_core = 1'b1;
    @(negedge clk);
    done_core = 1'b0;
    repeat (10) @(negedge clk);
    chk("spurious_done", 576'(done_seen - d0), 576'(0));
    chk("spurious_wr", 576'(wr_seen - w0), 576'(0));
    chk("post_rst_busy", 576'(busy), 576'(0));

    run_msg(rnd_msg(30));

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
